// File: rtl/arith_pkg.sv
// Shared types and helpers for the sequential integer arithmetic units
// (mul_add_int today, div_int when it is reworked).
package arith_pkg;

  typedef enum logic {IDLE, CALC} arith_state_e;

  function automatic int result_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mul_add_int.sv
// Radix-2 shift-and-add unit computing p = a*b + c, one iteration per clock,
// with the same start/busy/valid handshake as div_int.
module mul_add_int
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 busy,
  output logic                 valid,
  output logic                 ovf,
  output logic [2*WIDTH-1:0]   p
);

  localparam int RW = result_width(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  arith_state_e    r_state;
  arith_state_e    w_state_nxt;
  logic [RW-1:0]   r_mcand;
  logic [RW-1:0]   r_acc;
  logic [RW-1:0]   r_p;
  logic [RW-1:0]   w_acc_nxt;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic            r_ovf;
  logic            w_last;

  // The iteration that brings the counter to WIDTH is also the one that publishes p.
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_mcand  <= {{(RW-WIDTH){1'b0}}, a};
        r_mplier <= b;
        r_acc    <= {{(RW-WIDTH){1'b0}}, c};
        r_cnt    <= '0;
        r_valid  <= 1'b0;
      end
    end else begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_p     <= w_acc_nxt;
        r_ovf   <= |w_acc_nxt[RW-1:WIDTH];
        r_valid <= 1'b1;
      end
    end
  end

  assign busy  = (r_state == CALC);
  assign valid = r_valid;
  assign ovf   = r_ovf;
  assign p     = r_p;

endmodule

// File: tb/tb_mul_add_int.sv
// Directed bench for mul_add_int (WIDTH=4) with a transaction-level reference model.
module tb_mul_add_int;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0, b = '0, c = '0;
  logic           busy, valid, ovf;
  logic [2*W-1:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outputs at the transaction level.
  logic           m_busy = 1'b0, m_valid = 1'b0, m_ovf = 1'b0;
  int             m_p = 0, m_pend = 0, m_left = 0;

  mul_add_int #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .valid(valid), .ovf(ovf), .p(p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0; m_ovf = 1'b0; m_p = 0; m_left = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
        m_p     = m_pend;
        m_ovf   = (m_pend >= (1 << W));
      end
    end else if (start) begin
      m_busy  = 1'b1;
      m_valid = 1'b0;
      m_left  = W;
      m_pend  = int'(a) * int'(b) + int'(c);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_busy",  int'(busy),  int'(m_busy));
      chk("model_valid", int'(valid), int'(m_valid));
      chk("model_p",     int'(p),     m_p);
      chk("model_ovf",   int'(ovf),   int'(m_ovf));
    end
  end

  // One full operation with literal cycle-by-cycle expectations.
  task automatic run_op(input int ia, input int ib, input int ic,
                        input int exp_p, input int exp_ovf, input string tag);
    int old_p, old_ovf;
    @(posedge clk); #2;
    old_p = int'(p); old_ovf = int'(ovf);
    a = W'(ia); b = W'(ib); c = W'(ic); start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_k"},  int'(busy),  1);
    chk({tag, "_valid_k"}, int'(valid), 0);
    chk({tag, "_hold_p"},  int'(p),     old_p);
    chk({tag, "_hold_ovf"}, int'(ovf),  old_ovf);
    #1 start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      if (i < W) begin
        chk({tag, "_busy_mid"},  int'(busy),  1);
        chk({tag, "_valid_mid"}, int'(valid), 0);
      end else begin
        chk({tag, "_busy_end"},  int'(busy),  0);
        chk({tag, "_valid_end"}, int'(valid), 1);
        chk({tag, "_p"},         int'(p),     exp_p);
        chk({tag, "_ovf"},       int'(ovf),   exp_ovf);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_p", int'(p), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: basic
    run_op(3, 2, 1, 7, 0, "t1");
    // 2: maximum operands, then a small one
    run_op(15, 15, 15, 240, 1, "t2a");
    run_op(5, 3, 0, 15, 0, "t2b");
    // 3: zero operands keep full latency
    run_op(0, 9, 8, 8, 0, "t3a");
    run_op(7, 0, 0, 0, 0, "t3b");

    // 4: start while busy is ignored
    @(posedge clk); #2;
    a = 4'd2; b = 4'd2; c = 4'd0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    a = 4'd15; b = 4'd15; c = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    chk("t4_busy_ign", int'(busy), 1);
    #1 start = 1'b0;
    @(posedge clk); #1;
    chk("t4_valid", int'(valid), 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_p", int'(p), 4);
    chk("t4_ovf", int'(ovf), 0);

    // 5: asynchronous reset mid-calculation
    @(posedge clk); #2;
    a = 4'd6; b = 4'd6; c = 4'd0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_valid", int'(valid), 0);
    chk("t5_p", int'(p), 0);
    chk("t5_ovf", int'(ovf), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    run_op(1, 1, 1, 2, 0, "t5b");

    // 6: round trip from quotient/divisor/remainder back to dividend
    for (int x = 0; x < 16; x++)
      for (int y = 1; y < 16; y++)
        run_op(x / y, y, x % y, x, 0, "t6");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
